change_dispense_ctrl: RTL and testbench
=======================================

Name: change_dispense_ctrl

Overview:
- Sequences the coin-ejector mechanism to pay out change after a vend, using greedy selection in the order quarter, then dime, then nickel.
- Tracks the three coin-tube inventories and reports any unpaid remainder.
- The vend FSM hands it an amount in nickel units; it sits between that FSM and the ejector solenoid driver.

Parameters:
- TUBE_W, 6, width of each tube inventory counter (max 63 coins).
- AMT_W, 5, width of change amount in nickel units (max 31 = 155 cents).
- GAP_CYC, 2, idle cycles with eject_req low between consecutive ejections (range 1..15).
- ACK_TIMEOUT, 255, cycles to wait for eject_ack before declaring a jam (range 1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to pay out `amount`; honoured only in IDLE.
- amount  in  AMT_W  change owed, in nickels; sampled when start is accepted.
- load  in  1  inventory load strobe; honoured only in IDLE.
- load_q, load_d, load_n  in  TUBE_W each  quarter, dime and nickel tube counts written on load.
- eject_req  out  1  request to the ejector to drop one coin.
- eject_sel  out  3  one-hot coin select {quarter, dime, nickel}; 000 when eject_req is low.
- eject_ack  in  1  ejector reports the coin has dropped.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a payout finishes.
- short  out  1  valid with done; 1 if remaining != 0.
- jam  out  1  sticky; set on ack timeout, cleared on the next accepted start.
- remaining  out  AMT_W  unpaid nickels; holds its value after done.
- q_cnt, d_cnt, n_cnt  out  TUBE_W each  current tube inventories.
- low_change  out  1  combinational: (n_cnt < 2).

Behaviour:
- Reset (async): state=IDLE. All outputs 0, including counts and remaining. eject_req drops immediately, even mid-ejection; no partial decrement is applied.
- FSM states: IDLE, SELECT, EJECT, GAP, DONE.
- IDLE:
  - start=1: rem<=amount, jam<=0, go to SELECT.
  - load=1 (start=0): counts <= load values.
  - start and load in the same cycle: start wins, load is dropped.
- SELECT (one cycle). Evaluate in priority order:
  - rem>=5 and q_cnt>0 → sel=100.
  - else rem>=2 and d_cnt>0 → sel=010.
  - else rem>=1 and n_cnt>0 → sel=001.
  - else go to DONE.
  - When a coin is chosen: register eject_req=1 with sel, clear the timeout counter, go to EJECT.
- EJECT:
  - eject_req and eject_sel are held stable.
  - On eject_ack=1: rem -= coin value (5/2/1); decrement that tube; drop eject_req and eject_sel; load the gap counter with GAP_CYC; go to GAP.
  - Timeout counter reaches ACK_TIMEOUT with no ack: jam<=1, drop eject_req, no decrement, go to DONE.
  - Ack in the same cycle as timeout expiry: ack wins.
- GAP: count down GAP_CYC cycles with eject_req low, then go to SELECT.
- DONE: done=1 and short=(rem!=0) for exactly one cycle, then IDLE.
- remaining mirrors rem at all times.
- Ignored inputs:
  - start or load while busy.
  - eject_ack while eject_req is low.
- Underflow is impossible: a coin is only selected when both its tube count and rem cover it.
- Timing, amount=0: start at edge 0; SELECT after edge 1; done high after edge 2; IDLE after edge 3.
- Timing, first coin: eject_req rises after edge 2, which is 2 cycles after start.

Test Plan:
- Load q=4,d=4,n=4; start with amount=13 (65c), ack 1 cycle after each req. Required sequence: Q, Q, D, N. Counts end at q=2,d=3,n=3; done with short=0, remaining=0. Exactly GAP_CYC low cycles on eject_req between requests.
- Load q=0,d=1,n=0; start with amount=3. Required: one D ejection, then done with short=1, remaining=1, d_cnt=0.
- Start with amount=0. Required: no eject_req; done asserted 2 cycles after start; short=0.
- Load q=1; start with amount=5; never ack. Required: eject_req held for ACK_TIMEOUT cycles, then jam=1, done with short=1, remaining=5, q_cnt=1. Next start clears jam.
- Pulse start and load during EJECT. Required: both ignored, counts unchanged. Ack arriving while eject_req is low is ignored.
- Assert rst_n=0 mid-EJECT. Required: eject_req=0 and busy=0 immediately; counts and remaining read 0. After release, the block is IDLE and accepts load.

Source files
------------

// File: rtl/change_dispense_if.sv
// Signal bundle between the vend FSM / ejector side (master) and the change
// dispense controller (slave).
interface change_dispense_if #(
  parameter int TUBE_W = 6,
  parameter int AMT_W  = 5
);
  logic              start;
  logic [AMT_W-1:0]  amount;
  logic              load;
  logic [TUBE_W-1:0] load_q;
  logic [TUBE_W-1:0] load_d;
  logic [TUBE_W-1:0] load_n;
  logic              eject_req;
  logic [2:0]        eject_sel;
  logic              eject_ack;
  logic              busy;
  logic              done;
  logic              short;
  logic              jam;
  logic [AMT_W-1:0]  remaining;
  logic [TUBE_W-1:0] q_cnt;
  logic [TUBE_W-1:0] d_cnt;
  logic [TUBE_W-1:0] n_cnt;
  logic              low_change;

  modport master (
    output start, amount, load, load_q, load_d, load_n, eject_ack,
    input  eject_req, eject_sel, busy, done, short, jam, remaining,
           q_cnt, d_cnt, n_cnt, low_change
  );

  modport slave (
    input  start, amount, load, load_q, load_d, load_n, eject_ack,
    output eject_req, eject_sel, busy, done, short, jam, remaining,
           q_cnt, d_cnt, n_cnt, low_change
  );
endinterface

// File: rtl/change_dispense_ctrl.sv
// Greedy change payout sequencer (quarter, dime, nickel) driving a one-coin
// ejector handshake, with tube inventory tracking and ack-timeout jam detect.
module change_dispense_ctrl #(
  parameter int TUBE_W      = 6,
  parameter int AMT_W       = 5,
  parameter int GAP_CYC     = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  change_dispense_if.slave bus
);
  localparam int TMO_W = 8;
  localparam int GAP_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AMT_W-1:0]  rem;
  logic [TUBE_W-1:0] q_cnt;
  logic [TUBE_W-1:0] d_cnt;
  logic [TUBE_W-1:0] n_cnt;
  logic [2:0]        sel;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              jam;

  logic              pick_q;
  logic              pick_d;
  logic              pick_n;
  logic              coin_avail;
  logic              tmo_hit;

  function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] s);
    case (s)
      3'b100:  coin_value = AMT_W'(5);
      3'b010:  coin_value = AMT_W'(2);
      3'b001:  coin_value = AMT_W'(1);
      default: coin_value = '0;
    endcase
  endfunction

  // A coin is eligible only when both its tube and the remainder cover it.
  assign pick_q     = (rem >= AMT_W'(5)) && (q_cnt != '0);
  assign pick_d     = !pick_q && (rem >= AMT_W'(2)) && (d_cnt != '0);
  assign pick_n     = !pick_q && !pick_d && (rem != '0) && (n_cnt != '0);
  assign coin_avail = pick_q || pick_d || pick_n;
  assign tmo_hit    = (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // The SELECT cycle is the last of the GAP_CYC idle cycles between coins,
  // so GAP itself lasts GAP_CYC-1 cycles and is skipped when GAP_CYC is 1.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_SELECT;
      S_SELECT: state_nxt = coin_avail ? S_EJECT : S_DONE;
      S_EJECT: begin
        if (bus.eject_ack)  state_nxt = (GAP_CYC > 1) ? S_GAP : S_SELECT;
        else if (tmo_hit)   state_nxt = S_DONE;
      end
      S_GAP:    if (gap_cnt <= GAP_W'(2)) state_nxt = S_SELECT;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      q_cnt   <= '0;
      d_cnt   <= '0;
      n_cnt   <= '0;
      sel     <= '0;
      tmo_cnt <= '0;
      gap_cnt <= '0;
      jam     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            rem <= bus.amount;
            jam <= 1'b0;
          end else if (bus.load) begin
            q_cnt <= bus.load_q;
            d_cnt <= bus.load_d;
            n_cnt <= bus.load_n;
          end
        end
        S_SELECT: begin
          sel     <= {pick_q, pick_d, pick_n};
          tmo_cnt <= '0;
        end
        S_EJECT: begin
          // Ack beats a simultaneous timeout.
          if (bus.eject_ack) begin
            rem     <= rem - coin_value(sel);
            gap_cnt <= GAP_W'(GAP_CYC);
            if (sel[2]) q_cnt <= q_cnt - TUBE_W'(1);
            if (sel[1]) d_cnt <= d_cnt - TUBE_W'(1);
            if (sel[0]) n_cnt <= n_cnt - TUBE_W'(1);
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_hit) jam <= 1'b1;
          end
        end
        S_GAP:   gap_cnt <= gap_cnt - GAP_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy       = (state != S_IDLE);
    bus.eject_req  = (state == S_EJECT);
    bus.eject_sel  = (state == S_EJECT) ? sel : 3'b000;
    bus.done       = (state == S_DONE);
    bus.short      = (state == S_DONE) && (rem != '0);
    bus.jam        = jam;
    bus.remaining  = rem;
    bus.q_cnt      = q_cnt;
    bus.d_cnt      = d_cnt;
    bus.n_cnt      = n_cnt;
    bus.low_change = (n_cnt < TUBE_W'(2));
  end
endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: table of payout vectors plus
// hand-written timeout, ignored-input and mid-ejection reset sequences.
module tb_change_dispense_ctrl;
  localparam int TUBE_W      = 6;
  localparam int AMT_W       = 5;
  localparam int GAP_CYC     = 2;
  localparam int ACK_TIMEOUT = 255;

  logic clk;
  logic rst_n;

  change_dispense_if #(.TUBE_W(TUBE_W), .AMT_W(AMT_W)) bus ();

  change_dispense_ctrl #(
    .TUBE_W(TUBE_W), .AMT_W(AMT_W), .GAP_CYC(GAP_CYC), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // seq: one hex digit per coin, first coin in the low digit (1=Q, 2=D, 3=N)
  typedef struct {
    int          lq, ld, ln, amt;
    logic [31:0] seq;
    int          ncoin;
    int          eq, ed, en;
    int          eshort;
    int          erem;
  } vec_t;

  vec_t vecs [8];
  int   applied = 0;
  int   miss    = 0;

  task automatic check(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int q, input int d, input int n);
    bus.load_q = TUBE_W'(q);
    bus.load_d = TUBE_W'(d);
    bus.load_n = TUBE_W'(n);
    bus.load   = 1'b1;
    step();
    bus.load   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc, ncoin, first_req, gap_bad, sel_bad, low_run, req_age;
    int          done_seen, done_cyc, got_short, got_rem, code;
    logic [31:0] seq;
    logic [2:0]  cur_sel;
    do_load(v.lq, v.ld, v.ln);
    bus.amount = AMT_W'(v.amt);
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    cyc = 1; ncoin = 0; first_req = -1; gap_bad = 0; sel_bad = 0;
    low_run = 0; req_age = 0; done_seen = 0; done_cyc = -1;
    got_short = -1; got_rem = -1; seq = '0; cur_sel = '0;
    while (done_seen == 0 && cyc < 2000) begin
      if (bus.done) begin
        done_seen = 1;
        done_cyc  = cyc;
        got_short = int'(bus.short);
        got_rem   = int'(bus.remaining);
      end else if (bus.eject_req) begin
        if (req_age == 0) begin
          if (first_req < 0) first_req = cyc;
          else if (low_run != GAP_CYC) gap_bad++;
          case (bus.eject_sel)
            3'b100:  code = 1;
            3'b010:  code = 2;
            3'b001:  code = 3;
            default: code = 15;
          endcase
          if (ncoin < 8) seq = seq | (32'(code) << (4 * ncoin));
          ncoin++;
          cur_sel = bus.eject_sel;
        end else if (bus.eject_sel != cur_sel) begin
          sel_bad++;
        end
        req_age++;
        if (req_age == 2) bus.eject_ack = 1'b1;
        low_run = 0;
      end else begin
        bus.eject_ack = 1'b0;
        req_age = 0;
        low_run++;
        if (bus.eject_sel != 3'b000) sel_bad++;
      end
      if (done_seen == 0) begin
        step();
        cyc++;
      end
    end
    bus.eject_ack = 1'b0;
    check($sformatf("v%0d_done_seen", idx), done_seen, 1);
    check($sformatf("v%0d_seq", idx), int'(seq), int'(v.seq));
    check($sformatf("v%0d_ncoin", idx), ncoin, v.ncoin);
    check($sformatf("v%0d_first_req_cyc", idx), first_req, (v.ncoin > 0) ? 2 : -1);
    check($sformatf("v%0d_done_cyc", idx), done_cyc, 2 + v.ncoin * (GAP_CYC + 2));
    check($sformatf("v%0d_gap_bad", idx), gap_bad, 0);
    check($sformatf("v%0d_sel_bad", idx), sel_bad, 0);
    check($sformatf("v%0d_short", idx), got_short, v.eshort);
    check($sformatf("v%0d_remaining", idx), got_rem, v.erem);
    check($sformatf("v%0d_q_cnt", idx), int'(bus.q_cnt), v.eq);
    check($sformatf("v%0d_d_cnt", idx), int'(bus.d_cnt), v.ed);
    check($sformatf("v%0d_n_cnt", idx), int'(bus.n_cnt), v.en);
    check($sformatf("v%0d_jam", idx), int'(bus.jam), 0);
    check($sformatf("v%0d_low_change", idx), int'(bus.low_change), (v.en < 2) ? 1 : 0);
    step();
    check($sformatf("v%0d_done_pulse", idx), int'(bus.done), 0);
    check($sformatf("v%0d_idle_busy", idx), int'(bus.busy), 0);
  endtask

  initial begin
    int req_hi, cyc;
    //           lq ld ln amt  seq          n  eq ed en sh rem
    vecs[0] = '{4, 4, 4, 13, 32'h3211,   4, 2, 3, 3, 0, 0};
    vecs[1] = '{0, 1, 0, 3,  32'h2,      1, 0, 0, 0, 1, 1};
    vecs[2] = '{5, 5, 5, 0,  32'h0,      0, 5, 5, 5, 0, 0};
    vecs[3] = '{1, 2, 3, 31, 32'h333221, 6, 0, 0, 0, 1, 19};
    vecs[4] = '{0, 0, 10, 4, 32'h3333,   4, 0, 0, 6, 0, 0};
    vecs[5] = '{2, 0, 0, 9,  32'h1,      1, 1, 0, 0, 1, 4};
    vecs[6] = '{3, 0, 3, 12, 32'h3311,   4, 1, 0, 1, 0, 0};
    vecs[7] = '{0, 3, 1, 7,  32'h3222,   4, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.amount = '0; bus.load = 1'b0;
    bus.load_q = '0; bus.load_d = '0; bus.load_n = '0; bus.eject_ack = 1'b0;
    step();
    step();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_eject_req", int'(bus.eject_req), 0);
    check("rst_eject_sel", int'(bus.eject_sel), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_jam", int'(bus.jam), 0);
    check("rst_remaining", int'(bus.remaining), 0);
    check("rst_q_cnt", int'(bus.q_cnt), 0);
    check("rst_n_cnt", int'(bus.n_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Ack never arrives: jam after ACK_TIMEOUT cycles of eject_req
    do_load(1, 0, 0);
    bus.amount = AMT_W'(5);
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    req_hi = 0;
    cyc = 0;
    while (!bus.done && cyc < 1000) begin
      if (bus.eject_req) req_hi++;
      step();
      cyc++;
    end
    check("tmo_done_seen", int'(bus.done), 1);
    check("tmo_req_cycles", req_hi, ACK_TIMEOUT);
    check("tmo_jam", int'(bus.jam), 1);
    check("tmo_short", int'(bus.short), 1);
    check("tmo_remaining", int'(bus.remaining), 5);
    check("tmo_q_cnt", int'(bus.q_cnt), 1);
    step();
    check("tmo_jam_sticky", int'(bus.jam), 1);
    bus.amount = '0;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    check("tmo_jam_cleared", int'(bus.jam), 0);
    step();
    step();
    check("tmo_after_idle", int'(bus.busy), 0);

    // start/load during EJECT and acks while eject_req is low are ignored
    do_load(3, 3, 3);
    bus.amount = AMT_W'(7);
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    bus.eject_ack = 1'b1;
    step();
    bus.eject_ack = 1'b0;
    check("ign_req_q", int'(bus.eject_req), 1);
    check("ign_sel_q", int'(bus.eject_sel), 4);
    bus.amount = AMT_W'(31);
    bus.start  = 1'b1;
    bus.load_q = TUBE_W'(9); bus.load_d = TUBE_W'(9); bus.load_n = TUBE_W'(9);
    bus.load   = 1'b1;
    step();
    bus.start  = 1'b0;
    bus.load   = 1'b0;
    check("ign_req_held", int'(bus.eject_req), 1);
    check("ign_q_unchanged", int'(bus.q_cnt), 3);
    bus.eject_ack = 1'b1;
    step();
    check("ign_q_dec", int'(bus.q_cnt), 2);
    check("ign_gap_req_low", int'(bus.eject_req), 0);
    step();
    bus.eject_ack = 1'b0;
    step();
    check("ign_req_d", int'(bus.eject_req), 1);
    check("ign_sel_d", int'(bus.eject_sel), 2);
    check("ign_d_unchanged", int'(bus.d_cnt), 3);
    step();
    check("ign_req_d_held", int'(bus.eject_req), 1);
    bus.eject_ack = 1'b1;
    step();
    bus.eject_ack = 1'b0;
    check("ign_d_dec", int'(bus.d_cnt), 2);
    check("ign_remaining", int'(bus.remaining), 0);
    step();
    step();
    check("ign_done", int'(bus.done), 1);
    check("ign_short", int'(bus.short), 0);
    step();
    check("ign_final_q", int'(bus.q_cnt), 2);
    check("ign_final_n", int'(bus.n_cnt), 3);

    // Asynchronous reset in the middle of an ejection
    do_load(4, 4, 4);
    bus.amount = AMT_W'(13);
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    step();
    check("rstm_req_before", int'(bus.eject_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstm_eject_req", int'(bus.eject_req), 0);
    check("rstm_eject_sel", int'(bus.eject_sel), 0);
    check("rstm_busy", int'(bus.busy), 0);
    check("rstm_q_cnt", int'(bus.q_cnt), 0);
    check("rstm_remaining", int'(bus.remaining), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_load(1, 2, 3);
    check("rstm_load_q", int'(bus.q_cnt), 1);
    check("rstm_load_d", int'(bus.d_cnt), 2);
    check("rstm_load_n", int'(bus.n_cnt), 3);
    check("rstm_idle", int'(bus.busy), 0);
    check("rstm_low_change", int'(bus.low_change), 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miss);
    $finish;
  end
endmodule
